// File: rtl/hedios_serial_tx_mp.sv
// hedios_serial_tx_mp: buffers {command, payload} packets in a FIFO and sends
// each one as a back-to-back burst of 8N1 UART bytes, followed by an idle gap.
// Build option: define HEDIOS_TX_CHECKSUM_EN to append an XOR checksum byte
// (command ^ all payload bytes) to every frame.
module hedios_serial_tx_mp #(
    parameter int CLK_RATE   = 100_000_000,
    parameter int BAUD_RATE  = 1_000_000,
    parameter int DATA_BYTES = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int GAP_BITS   = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    packet_command,
    input  logic [8*DATA_BYTES-1:0]       packet_data,
    input  logic                          push_packet,
    output logic                          queue_full,
    output logic                          queue_empty,
    output logic [$clog2(FIFO_DEPTH):0]   queue_level,
    output logic                          overflow,
    output logic                          busy,
    output logic                          tx_line
);

    localparam int CLKS_PER_BIT = CLK_RATE / BAUD_RATE;
    localparam int PKT_W        = 8 * (DATA_BYTES + 1);
`ifdef HEDIOS_TX_CHECKSUM_EN
    localparam int FRAME_BYTES  = DATA_BYTES + 2;
`else
    localparam int FRAME_BYTES  = DATA_BYTES + 1;
`endif
    localparam int FRAME_W      = 8 * FRAME_BYTES;
    localparam int AW           = $clog2(FIFO_DEPTH);
    localparam int LW           = AW + 1;
    localparam int CW           = $clog2(CLKS_PER_BIT);
    localparam int BW           = $clog2(FRAME_BYTES);

    typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP, GAP} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       clk_cnt_q, clk_cnt_d;
    logic [7:0]          bit_cnt_q, bit_cnt_d;
    logic [BW-1:0]       byte_idx_q, byte_idx_d;
    logic [FRAME_W-1:0]  frame_q, frame_d;
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]       level_q, level_d;
    logic                overflow_q, overflow_d;
    logic                tx_q, tx_d;
    logic [PKT_W-1:0]    slot_q [FIFO_DEPTH];

    logic                full;
    logic                pop;
    logic                push_ok;
    logic                bit_end;

`ifdef HEDIOS_TX_CHECKSUM_EN
    function automatic logic [7:0] checksum(input logic [PKT_W-1:0] pkt);
        logic [7:0] acc;
        acc = 8'h00;
        for (int i = 0; i < DATA_BYTES + 1; i++) begin
            acc = acc ^ pkt[8*i +: 8];
        end
        return acc;
    endfunction
`endif

    // FIFO bookkeeping: pop only from IDLE; a push into a full queue survives only if a pop frees a slot
    always_comb begin
        full       = (level_q == LW'(FIFO_DEPTH));
        pop        = (state_q == IDLE) && (level_q != '0);
        push_ok    = push_packet && (!full || pop);
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q | (push_packet & ~push_ok);
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push_ok && !pop) begin
            level_d = level_q + LW'(1);
        end else if (pop && !push_ok) begin
            level_d = level_q - LW'(1);
        end
    end

    // Serialiser: next state, bit/byte counters, frame shifting and the next line level
    always_comb begin
        state_d    = state_q;
        clk_cnt_d  = clk_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        byte_idx_d = byte_idx_q;
        frame_d    = frame_q;
        bit_end    = (clk_cnt_q == CW'(CLKS_PER_BIT - 1));
        case (state_q)
            IDLE: begin
                clk_cnt_d = '0;
                if (pop) begin
                    // Capture the head now: a same-cycle push may reuse this slot
                    frame_d = FRAME_W'(slot_q[rd_ptr_q]);
                    state_d = LOAD;
                end
            end
            LOAD: begin
`ifdef HEDIOS_TX_CHECKSUM_EN
                frame_d[FRAME_W-1 -: 8] = checksum(frame_q[PKT_W-1:0]);
`endif
                byte_idx_d = '0;
                clk_cnt_d  = '0;
                state_d    = START;
            end
            START: begin
                clk_cnt_d = bit_end ? '0 : clk_cnt_q + CW'(1);
                if (bit_end) begin
                    bit_cnt_d = '0;
                    state_d   = DATA;
                end
            end
            DATA: begin
                clk_cnt_d = bit_end ? '0 : clk_cnt_q + CW'(1);
                if (bit_end) begin
                    // After 8 shifts the next byte sits in frame[7:0]
                    frame_d   = frame_q >> 1;
                    bit_cnt_d = bit_cnt_q + 8'd1;
                    if (bit_cnt_q == 8'd7) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                clk_cnt_d = bit_end ? '0 : clk_cnt_q + CW'(1);
                if (bit_end) begin
                    bit_cnt_d = '0;
                    if (byte_idx_q == BW'(FRAME_BYTES - 1)) begin
                        state_d = (GAP_BITS == 0) ? IDLE : GAP;
                    end else begin
                        byte_idx_d = byte_idx_q + BW'(1);
                        state_d    = START;
                    end
                end
            end
            GAP: begin
                clk_cnt_d = bit_end ? '0 : clk_cnt_q + CW'(1);
                if (bit_end) begin
                    if (bit_cnt_q == 8'(GAP_BITS - 1)) begin
                        state_d = IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 8'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        tx_d = 1'b1;
        if (state_d == START) begin
            tx_d = 1'b0;
        end else if (state_d == DATA) begin
            tx_d = frame_d[0];
        end
    end

    // Control registers: FSM, counters, FIFO pointers, flags and the registered line driver
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            clk_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            byte_idx_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            clk_cnt_q  <= clk_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_idx_q <= byte_idx_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            tx_q       <= tx_d;
        end
    end

    // Packet storage and frame register hold data only and are left unreset
    always_ff @(posedge clk) begin
        if (push_ok && !rst) begin
            slot_q[wr_ptr_q] <= {packet_data, packet_command};
        end
        frame_q <= frame_d;
    end

    assign queue_full  = full;
    assign queue_empty = (level_q == '0);
    assign queue_level = level_q;
    assign overflow    = overflow_q;
    assign busy        = (state_q != IDLE);
    assign tx_line     = tx_q;

endmodule
